// File: rtl/complex_nr_mult_gen.sv
// Time-multiplexed complex multiplier (a+jb)*(c+jd) with NUM_MULT shared integer multipliers.
// Products are built over 4/NUM_MULT phases, summed in one cycle, and handed off via valid/ready.
module complex_nr_mult_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_MULT   = 2,
    parameter int SIGNED     = 0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    sw_rst,
    input  logic                    op_val,
    output logic                    op_ready,
    input  logic [DATA_WIDTH-1:0]   op_1_re,
    input  logic [DATA_WIDTH-1:0]   op_1_im,
    input  logic [DATA_WIDTH-1:0]   op_2_re,
    input  logic [DATA_WIDTH-1:0]   op_2_im,
    output logic                    res_val,
    input  logic                    res_ready,
    output logic [2*DATA_WIDTH:0]   result_re,
    output logic [2*DATA_WIDTH:0]   result_im
);

    localparam int DW   = DATA_WIDTH;
    localparam int PW   = 2 * DATA_WIDTH;
    localparam int RW   = 2 * DATA_WIDTH + 1;
    localparam int N_PH = 4 / NUM_MULT;
    localparam logic [1:0] PH_LAST = 2'(N_PH - 1);

    generate
        if (!(NUM_MULT == 1 || NUM_MULT == 2 || NUM_MULT == 4)) begin : g_bad_num_mult
            $error("complex_nr_mult_gen: NUM_MULT must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, MUL, SUM, DONE} state_t;

    state_t            state_q;
    logic [DW-1:0]     a_q, b_q, c_q, d_q;
    logic [1:0]        phase_q;
    logic [PW-1:0]     prod_q [4];
    logic [RW-1:0]     res_re_q, res_im_q;

    logic [PW-1:0]     mult_res [NUM_MULT];
    logic [1:0]        mult_idx [NUM_MULT];
    logic [RW-1:0]     ext_p    [4];
    logic [RW-1:0]     sum_re_d, sum_im_d;
    logic              accept;

    // Product index k: 0=a*c, 1=b*d, 2=a*d, 3=b*c. Bit 0 picks a/b, bit0^bit1 picks c/d.
    generate
        for (genvar gi = 0; gi < NUM_MULT; gi++) begin : g_mult
            logic [DW-1:0] x, y;
            logic [PW-1:0] xe, ye;
            logic          sx, sy;
            assign mult_idx[gi] = 2'(int'(phase_q) * NUM_MULT + gi);
            assign x  = mult_idx[gi][0] ? b_q : a_q;
            assign y  = (mult_idx[gi][0] ^ mult_idx[gi][1]) ? d_q : c_q;
            assign sx = (SIGNED != 0) & x[DW-1];
            assign sy = (SIGNED != 0) & y[DW-1];
            assign xe = {{DW{sx}}, x};
            assign ye = {{DW{sy}}, y};
            // Low PW bits of the extended product equal the true signed/unsigned product.
            assign mult_res[gi] = xe * ye;
        end

        for (genvar gi = 0; gi < 4; gi++) begin : g_ext
            assign ext_p[gi] = {(SIGNED != 0) & prod_q[gi][PW-1], prod_q[gi]};
        end
    endgenerate

    assign sum_re_d = ext_p[0] - ext_p[1];
    assign sum_im_d = ext_p[2] + ext_p[3];

    assign op_ready  = (state_q == IDLE) || ((state_q == DONE) && res_ready);
    assign accept    = op_ready && op_val;
    assign res_val   = (state_q == DONE);
    assign result_re = res_re_q;
    assign result_im = res_im_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            res_re_q <= '0;
            res_im_q <= '0;
            for (int i = 0; i < 4; i++) prod_q[i] <= '0;
        end else if (sw_rst) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            res_re_q <= '0;
            res_im_q <= '0;
            for (int i = 0; i < 4; i++) prod_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        a_q     <= op_1_re;
                        b_q     <= op_1_im;
                        c_q     <= op_2_re;
                        d_q     <= op_2_im;
                        phase_q <= '0;
                        state_q <= MUL;
                    end else if (state_q == DONE && res_ready) begin
                        state_q <= IDLE;
                    end
                end
                MUL: begin
                    for (int i = 0; i < NUM_MULT; i++) prod_q[mult_idx[i]] <= mult_res[i];
                    phase_q <= phase_q + 2'd1;
                    if (phase_q == PH_LAST) state_q <= SUM;
                end
                SUM: begin
                    res_re_q <= sum_re_d;
                    res_im_q <= sum_im_d;
                    state_q  <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_complex_nr_mult_gen.sv
// Directed bench: three instances (NUM_MULT=2 unsigned, 1 unsigned, 4 signed) driven by scenario tasks.
module tb_complex_nr_mult_gen;

    logic        clk = 1'b0;
    logic        rstn      [3];
    logic        sw_rst    [3];
    logic        op_val    [3];
    logic        op_ready  [3];
    logic        res_val   [3];
    logic        res_ready [3];
    logic [7:0]  o1re [3], o1im [3], o2re [3], o2im [3];
    logic [16:0] rre  [3], rim  [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            complex_nr_mult_gen #(
                .DATA_WIDTH(8),
                .NUM_MULT  (gi == 0 ? 2 : (gi == 1 ? 1 : 4)),
                .SIGNED    (gi == 2 ? 1 : 0)
            ) u_dut (
                .clk      (clk),
                .rstn     (rstn[gi]),
                .sw_rst   (sw_rst[gi]),
                .op_val   (op_val[gi]),
                .op_ready (op_ready[gi]),
                .op_1_re  (o1re[gi]),
                .op_1_im  (o1im[gi]),
                .op_2_re  (o2re[gi]),
                .op_2_im  (o2im[gi]),
                .res_val  (res_val[gi]),
                .res_ready(res_ready[gi]),
                .result_re(rre[gi]),
                .result_im(rim[gi])
            );
        end
    endgenerate

    // One transaction: capture, count edges until res_val, check results; hold=1 leaves it in DONE.
    task automatic run_txn(input int u, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d,
                           input logic [16:0] er, input logic [16:0] ei,
                           input int elat, input bit hold, input string nm);
        int n;
        bit seen;
        @(negedge clk);
        o1re[u] = a; o1im[u] = b; o2re[u] = c; o2im[u] = d;
        op_val[u] = 1'b1;
        res_ready[u] = !hold;
        #1;
        checks++;
        if (op_ready[u] !== 1'b1) begin
            errors++;
            $display("FAIL %s op_ready_at_accept got=%0b want=1", nm, op_ready[u]);
        end
        @(posedge clk);
        @(negedge clk);
        op_val[u] = 1'b0;
        checks++;
        if (op_ready[u] !== 1'b0 || res_val[u] !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_after_capture op_ready=%0b res_val=%0b want 0/0", nm, op_ready[u], res_val[u]);
        end
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (res_val[u] === 1'b1) seen = 1'b1;
            else begin
                checks++;
                if (op_ready[u] !== 1'b0) begin
                    errors++;
                    $display("FAIL %s op_ready_busy edge=%0d got=%0b want=0", nm, n, op_ready[u]);
                end
            end
        end
        checks++;
        if (!seen || n != elat) begin
            errors++;
            $display("FAIL %s latency got=%0d want=%0d seen=%0b", nm, n, elat, seen);
        end
        checks++;
        if (rre[u] !== er) begin
            errors++;
            $display("FAIL %s result_re got=%h want=%h", nm, rre[u], er);
        end
        checks++;
        if (rim[u] !== ei) begin
            errors++;
            $display("FAIL %s result_im got=%h want=%h", nm, rim[u], ei);
        end
        $display("txn %s: inst=%0d re=%h im=%h latency=%0d", nm, u, rre[u], rim[u], n);
        if (!hold) begin
            @(negedge clk);
            checks++;
            if (res_val[u] !== 1'b0) begin
                errors++;
                $display("FAIL %s res_val_one_cycle got=%0b want=0", nm, res_val[u]);
            end
        end
    endtask

    task automatic test_reset();
        for (int u = 0; u < 3; u++) begin
            rstn[u] = 1'b0; sw_rst[u] = 1'b0; op_val[u] = 1'b0; res_ready[u] = 1'b0;
            o1re[u] = '0; o1im[u] = '0; o2re[u] = '0; o2im[u] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 3; u++) rstn[u] = 1'b1;
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            checks++;
            if (res_val[u] !== 1'b0) begin errors++; $display("FAIL reset_res_val inst=%0d got=%0b want=0", u, res_val[u]); end
            checks++;
            if (op_ready[u] !== 1'b1) begin errors++; $display("FAIL reset_op_ready inst=%0d got=%0b want=1", u, op_ready[u]); end
            checks++;
            if (rre[u] !== 17'h0) begin errors++; $display("FAIL reset_result_re inst=%0d got=%h want=0", u, rre[u]); end
            checks++;
            if (rim[u] !== 17'h0) begin errors++; $display("FAIL reset_result_im inst=%0d got=%h want=0", u, rim[u]); end
        end
        $display("txn reset: all instances checked");
    endtask

    task automatic test_nm2_unsigned();
        run_txn(0, 8'd3, 8'd4, 8'd5, 8'd6, 17'h1FFF7, 17'd38, 3, 1'b0, "nm2_3p4j_x_5p6j");
    endtask

    task automatic test_nm1_unsigned();
        run_txn(1, 8'd255, 8'd255, 8'd255, 8'd255, 17'h00000, 17'h1FC02, 5, 1'b0, "nm1_max_sq");
        run_txn(1, 8'd0, 8'd255, 8'd0, 8'd255, 17'h101FF, 17'h00000, 5, 1'b0, "nm1_j255_sq");
    endtask

    task automatic test_nm4_signed();
        run_txn(2, 8'h80, 8'h80, 8'h80, 8'h80, 17'h00000, 17'h08000, 2, 1'b0, "nm4_min_sq");
        run_txn(2, 8'hFF, 8'h02, 8'h03, 8'hFC, 17'd5, 17'd10, 2, 1'b0, "nm4_m1p2j_x_3m4j");
    endtask

    task automatic test_backpressure();
        int n;
        bit seen;
        run_txn(0, 8'd7, 8'd1, 8'd2, 8'd3, 17'd11, 17'd23, 3, 1'b1, "bp_first");
        o1re[0] = 8'd1; o1im[0] = 8'd2; o2re[0] = 8'd3; o2im[0] = 8'd4;
        op_val[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (op_ready[0] !== 1'b0 || res_val[0] !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d op_ready=%0b res_val=%0b want 0/1", i, op_ready[0], res_val[0]);
            end
            checks++;
            if (rre[0] !== 17'd11 || rim[0] !== 17'd23) begin
                errors++;
                $display("FAIL bp_hold_result cyc=%0d got=%h/%h want=%h/%h", i, rre[0], rim[0], 17'd11, 17'd23);
            end
        end
        res_ready[0] = 1'b1;
        #1;
        checks++;
        if (op_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_op_ready got=%0b want=1", op_ready[0]);
        end
        @(posedge clk);
        @(negedge clk);
        op_val[0] = 1'b0;
        checks++;
        if (res_val[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_res_val_drop got=%0b want=0", res_val[0]);
        end
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (res_val[0] === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || n != 3) begin
            errors++;
            $display("FAIL bp_second_latency got=%0d want=3 seen=%0b", n, seen);
        end
        checks++;
        if (rre[0] !== 17'h1FFFB || rim[0] !== 17'd10) begin
            errors++;
            $display("FAIL bp_second_result got=%h/%h want=%h/%h", rre[0], rim[0], 17'h1FFFB, 17'd10);
        end
        $display("txn bp_second: re=%h im=%h latency=%0d", rre[0], rim[0], n);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0]  va [4], vb [4], vc [4], vd [4];
        logic [16:0] ere [4], eim [4];
        int sent, got, cyc, last_cyc, cap_cyc;
        bit acc;
        va = '{8'd3, 8'hFF, 8'h80, 8'd127};
        vb = '{8'd4, 8'h02, 8'h80, 8'd0};
        vc = '{8'd5, 8'h03, 8'h80, 8'h80};
        vd = '{8'd6, 8'hFC, 8'h80, 8'd1};
        ere = '{17'h1FFF7, 17'd5, 17'h00000, 17'h1C080};
        eim = '{17'd38, 17'd10, 17'h08000, 17'd127};
        sent = 0; got = 0; cyc = 0; last_cyc = 0; cap_cyc = 0;
        @(negedge clk);
        res_ready[2] = 1'b1;
        o1re[2] = va[0]; o1im[2] = vb[0]; o2re[2] = vc[0]; o2im[2] = vd[0];
        op_val[2] = 1'b1;
        while (got < 4 && cyc < 60) begin
            #1;
            acc = op_ready[2] && op_val[2];
            @(posedge clk);
            cyc++;
            if (acc) begin
                sent++;
                if (sent == 1) cap_cyc = cyc;
            end
            @(negedge clk);
            if (acc) begin
                if (sent < 4) begin
                    o1re[2] = va[sent]; o1im[2] = vb[sent]; o2re[2] = vc[sent]; o2im[2] = vd[sent];
                end else op_val[2] = 1'b0;
            end
            if (res_val[2] === 1'b1) begin
                checks++;
                if (rre[2] !== ere[got] || rim[2] !== eim[got]) begin
                    errors++;
                    $display("FAIL b2b_result idx=%0d got=%h/%h want=%h/%h", got, rre[2], rim[2], ere[got], eim[got]);
                end
                checks++;
                if ((got == 0 && cyc - cap_cyc != 2) || (got != 0 && cyc - last_cyc != 3)) begin
                    errors++;
                    $display("FAIL b2b_spacing idx=%0d got=%0d want=%0d", got,
                             (got == 0) ? cyc - cap_cyc : cyc - last_cyc, (got == 0) ? 2 : 3);
                end
                $display("txn b2b idx=%0d: re=%h im=%h cycle=%0d", got, rre[2], rim[2], cyc);
                last_cyc = cyc;
                got++;
            end
        end
        checks++;
        if (got != 4) begin
            errors++;
            $display("FAIL b2b_count got=%0d want=4", got);
        end
        op_val[2] = 1'b0;
    endtask

    task automatic test_sw_rst_abort();
        int stray;
        @(negedge clk);
        o1re[1] = 8'd9; o1im[1] = 8'd9; o2re[1] = 8'd9; o2im[1] = 8'd9;
        op_val[1] = 1'b1;
        res_ready[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_val[1] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        sw_rst[1] = 1'b1;
        op_val[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sw_rst[1] = 1'b0;
        op_val[1] = 1'b0;
        checks++;
        if (op_ready[1] !== 1'b1 || res_val[1] !== 1'b0) begin
            errors++;
            $display("FAIL swrst_state op_ready=%0b res_val=%0b want 1/0", op_ready[1], res_val[1]);
        end
        checks++;
        if (rre[1] !== 17'h0 || rim[1] !== 17'h0) begin
            errors++;
            $display("FAIL swrst_results got=%h/%h want=0/0", rre[1], rim[1]);
        end
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_val[1] !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL swrst_stray_res_val got=%0d want=0", stray);
        end
        $display("txn swrst_abort: stray=%0d", stray);
        run_txn(1, 8'd1, 8'd1, 8'd1, 8'd1, 17'h0, 17'd2, 5, 1'b0, "post_swrst");
    endtask

    task automatic test_rstn_async();
        run_txn(1, 8'd2, 8'd3, 8'd4, 8'd5, 17'h1FFF9, 17'd22, 5, 1'b1, "pre_rstn");
        #2;
        rstn[1] = 1'b0;
        #1;
        checks++;
        if (res_val[1] !== 1'b0 || op_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL rstn_async_state res_val=%0b op_ready=%0b want 0/1", res_val[1], op_ready[1]);
        end
        checks++;
        if (rre[1] !== 17'h0 || rim[1] !== 17'h0) begin
            errors++;
            $display("FAIL rstn_async_results got=%h/%h want=0/0", rre[1], rim[1]);
        end
        $display("txn rstn_async: res_val=%0b re=%h im=%h", res_val[1], rre[1], rim[1]);
        @(negedge clk);
        rstn[1] = 1'b1;
        res_ready[1] = 1'b1;
        run_txn(1, 8'd1, 8'd0, 8'd1, 8'd0, 17'd1, 17'd0, 5, 1'b0, "post_rstn");
    endtask

    initial begin
        test_reset();
        test_nm2_unsigned();
        test_nm1_unsigned();
        test_nm4_signed();
        test_backpressure();
        test_back_to_back();
        test_sw_rst_abort();
        test_rstn_async();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
